msgpass_rd_addr_gen: RTL
========================

MSGPASS_RD_ADDR_GEN -- requirements
Module: msgpass_rd_addr_gen

Interface
REQ-001 SHALL have parameter MSGPASS_BUFF_ADDR_WIDTH, default 3, read-address width of the message-pass buffer.
REQ-002 SHALL have parameter MSGPASS_BUFF_DEPTH, default 5, number of buffer entries, with 1 <= DEPTH <= 2^ADDR_WIDTH.
REQ-003 SHALL have parameter MEMSHARE_DRC_NUM, default 1, width of the DRC flag vector from memShare_control_wrapper.
REQ-004 SHALL have port sys_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port buffer_read_begin_i, input, 1 bit: single-cycle start pulse.
REQ-007 SHALL have port base_addr_i, input, MSGPASS_BUFF_ADDR_WIDTH bits: first entry to read, sampled on start.
REQ-008 SHALL have port rqst_len_i, input, MSGPASS_BUFF_ADDR_WIDTH+1 bits: number of entries to issue, sampled on start.
REQ-009 SHALL have port is_drc_i, input, MEMSHARE_DRC_NUM bits: decomposition-required flags from the downstream memShare control.
REQ-010 SHALL have port raddr_o, output, MSGPASS_BUFF_ADDR_WIDTH bits: read address to the buffer port A.
REQ-011 SHALL have port rd_en_o, output, 1 bit: raddr_o carries a live request this cycle.
REQ-012 SHALL have port rqst_valid_o, output, 1 bit: buffer rdata (downstream rqst_addr_i) is valid this cycle.
REQ-013 SHALL have port busy_o, output, 1 bit: sequence in progress (state other than IDLE).
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse at sequence completion.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FLUSH, DONE, all registered.
REQ-016 In IDLE, on buffer_read_begin_i=1, SHALL latch base_addr_i into the address register and rqst_len_i into the remaining counter; go to RUN if len>0, else to DONE.
REQ-017 In RUN, SHALL drive rd_en_o=1 and raddr_o equal to the address register every cycle.
REQ-018 In RUN with |is_drc_i=0, SHALL advance the address by 1, wrapping from MSGPASS_BUFF_DEPTH-1 to 0, and decrement the remaining counter.
REQ-019 In RUN with |is_drc_i=1, SHALL hold the address and counter, re-issuing the same entry next cycle; consecutive DRC cycles extend the hold indefinitely.
REQ-020 SHALL go RUN->FLUSH when remaining=1 and |is_drc_i=0; FLUSH lasts one cycle with rd_en_o=0.
REQ-021 SHALL go FLUSH->DONE and DONE->IDLE unconditionally; done_o=1 only in DONE.
REQ-022 SHALL drive rqst_valid_o as rd_en_o delayed one cycle (buffer read latency 1).
REQ-023 SHALL ignore buffer_read_begin_i outside IDLE, including in the same cycle as done_o.
REQ-024 SHALL ignore is_drc_i outside RUN.
REQ-025 rqst_len_i greater than 2^ADDR_WIDTH is legal; the address wraps repeatedly.
REQ-026 SHALL drive raddr_o to the address register in all states (0 after reset).

Reset
REQ-027 With rstn=0 at a clock edge, SHALL enter IDLE with address=0, counter=0, rd_en_o=0, rqst_valid_o=0, busy_o=0, done_o=0.
REQ-028 Reset mid-sequence SHALL abort without a done_o pulse; rqst_valid_o is 0 in the first cycle after reset.

Structure
REQ-029 The state enum, MSGPASS_BUFF_ADDR_WIDTH, MSGPASS_BUFF_DEPTH and the read latency constant SHALL live in msgPass_config_pkg; MEMSHARE_DRC_NUM comes from memShare_config_pkg.
REQ-030 The wrapping address counter SHALL be a sub-module msgpass_wrap_cnt (inc, hold, load, wrap-at-DEPTH-1).

Verification
REQ-031 Start with base=0, len=3, no DRC -> raddr_o 0,1,2 with rd_en_o in cycles 1-3 after start, rqst_valid_o in cycles 2-4, done_o in cycle 5.
REQ-032 Start with base=0, len=3, is_drc_i=1 in the cycle raddr_o=1 -> raddr_o sequence 0,1,1,2; done_o in cycle 6.
REQ-033 Start with base=3, len=4, DEPTH=5 -> raddr_o sequence 3,4,0,1.
REQ-034 Start with len=0 -> no rd_en_o, done_o in cycle 1; a second start pulse during RUN is ignored and the address sequence is unchanged.
REQ-035 rstn=0 at the second RUN cycle -> all outputs at reset values next cycle, no done_o; a new start then gives a clean sequence.

Source files
------------

// File: rtl/memShare_config_pkg.sv
// Shared configuration for the downstream memShare control path.
// Constants only; no logic, no latency.
// No flow control.
package memShare_config_pkg;
    localparam int MEMSHARE_DRC_NUM = 1;
endpackage

// File: rtl/msgPass_config_pkg.sv
// Message-pass buffer geometry, read-sequencer states and buffer read latency.
// Constants only; no logic, no latency.
// No flow control.
package msgPass_config_pkg;
    localparam int MSGPASS_BUFF_ADDR_WIDTH = 3;
    localparam int MSGPASS_BUFF_DEPTH      = 5;
    localparam int MSGPASS_RD_LATENCY      = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } msgpass_rd_state_e;
endpackage

// File: rtl/msgpass_wrap_cnt.sv
// Loadable address counter that wraps from DEPTH-1 back to 0.
// Latency: one cycle from load_i/inc_i to cnt_o.
// Holds its value whenever neither load_i nor inc_i is asserted.
module msgpass_wrap_cnt #(
    parameter int W     = 3,
    parameter int DEPTH = 5
) (
    input  logic         sys_clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/msgpass_rd_addr_gen.sv
// Issues a run of wrapping read addresses into the message-pass buffer.
// Latency: first rd_en_o one cycle after start; rqst_valid_o trails rd_en_o by the buffer read latency.
// A DRC flag from downstream stalls the sequence, re-issuing the current entry until it clears.
module msgpass_rd_addr_gen #(
    parameter int MSGPASS_BUFF_ADDR_WIDTH = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH,
    parameter int MSGPASS_BUFF_DEPTH      = msgPass_config_pkg::MSGPASS_BUFF_DEPTH,
    parameter int MEMSHARE_DRC_NUM        = memShare_config_pkg::MEMSHARE_DRC_NUM
) (
    input  logic                               sys_clk,
    input  logic                               rstn,
    input  logic                               buffer_read_begin_i,
    input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [MSGPASS_BUFF_ADDR_WIDTH:0]   rqst_len_i,
    input  logic [MEMSHARE_DRC_NUM-1:0]        is_drc_i,
    output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] raddr_o,
    output logic                               rd_en_o,
    output logic                               rqst_valid_o,
    output logic                               busy_o,
    output logic                               done_o
);
    import msgPass_config_pkg::*;

    localparam int AW  = MSGPASS_BUFF_ADDR_WIDTH;
    localparam int LAT = MSGPASS_RD_LATENCY;
    localparam logic [AW:0] REM_ONE = (AW+1)'(1);

    msgpass_rd_state_e state_q;
    logic [AW:0]       remain_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;
    logic [LAT-1:0]    vld_pipe_q;

    logic start;
    logic stall;
    logic addr_inc;

    assign start    = (state_q == ST_IDLE) && buffer_read_begin_i;
    assign stall    = |is_drc_i;
    assign addr_inc = (state_q == ST_RUN) && !stall;

    msgpass_wrap_cnt #(
        .W     (AW),
        .DEPTH (MSGPASS_BUFF_DEPTH)
    ) u_addr_cnt (
        .sys_clk    (sys_clk),
        .rstn       (rstn),
        .load_i     (start),
        .load_val_i (base_addr_i),
        .inc_i      (addr_inc),
        .cnt_o      (raddr_o)
    );

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (buffer_read_begin_i) begin
                        remain_q <= rqst_len_i;
                        busy_q   <= 1'b1;
                        if (rqst_len_i != '0) begin
                            state_q <= ST_RUN;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == REM_ONE) begin
                            state_q <= ST_FLUSH;
                            rd_en_q <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // rdata becomes valid LAT cycles after the address is presented
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= rd_en_q;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
        end
    end

    assign rd_en_o      = rd_en_q;
    assign rqst_valid_o = vld_pipe_q[LAT-1];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule
